uart_transmitter: RTL and testbench

//   8N1 UART transmit path, mirror of the uart receiver: accepts bytes over a valid/ready

---
 rtl/uart_transmitter.sv | 155 +++++++++++++++
 tb/tb_uart_transmitter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// Purpose: 8N1 UART transmitter with a byte FIFO in front of an LSB-first serialiser.
// Latency: a byte accepted at edge N by an idle, empty block drives the start bit after edge N+2.
// Backpressure: tx_ready = !full; tx_valid while full is ignored and the producer holds the byte.
module uart_transmitter #(
    parameter int WAIT_CYCLES = 234,
    parameter int FIFO_DEPTH  = 4,
    parameter int STOP_BITS   = 1
) (
    input  logic       clk,
    input  logic       btn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_tx,
    output logic       tx_busy
);

    localparam int CW = $clog2(WAIT_CYCLES);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cyc_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [7:0]    fifo_head;
    logic          bit_end;
    logic          stop_done;

    // The extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];
    assign tx_ready   = !fifo_full;
    assign push       = tx_valid && !fifo_full;

    // Last clock of the current bit period, and last clock of the final stop bit.
    assign bit_end    = (cyc_cnt == CW'(WAIT_CYCLES - 1));
    assign stop_done  = bit_end && (bit_idx == 3'(STOP_BITS - 1));

    // The serialiser takes the head byte when idle, or straight out of the last stop bit
    // so consecutive frames have no idle gap between them.
    assign pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && stop_done));

    // Storage array: written on an accepted handshake, contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= tx_data;
        end
    end

    // Pointer update; push and pop in one clock both advance, leaving occupancy unchanged.
    always_ff @(posedge clk or negedge btn) begin
        if (!btn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Frame FSM; uart_tx and tx_busy are registered from the current state, so the line
    // lags the state by one clock and every bit lasts exactly WAIT_CYCLES clocks.
    always_ff @(posedge clk or negedge btn) begin
        if (!btn) begin
            state     <= IDLE;
            cyc_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            uart_tx   <= 1'b1;
            tx_busy   <= 1'b0;
        end else begin
            tx_busy <= (state != IDLE) || !fifo_empty;
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (pop) begin
                        shift_reg <= fifo_head;
                        state     <= START;
                        cyc_cnt   <= '0;
                        bit_idx   <= '0;
                    end
                end
                START: begin
                    uart_tx <= 1'b0;
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
                DATA: begin
                    uart_tx <= shift_reg[0];
                    if (bit_end) begin
                        cyc_cnt   <= '0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
                STOP: begin
                    uart_tx <= 1'b1;
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (stop_done) begin
                            bit_idx <= '0;
                            if (pop) begin
                                shift_reg <= fifo_head;
                                state     <= START;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       btn;
    logic [7:0] tx_data, tx_data2;
    logic       tx_valid, tx_valid2;
    logic       tx_ready, uart_tx, tx_busy;
    logic       tx_ready2, uart_tx2, tx_busy2;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    always #1 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_transmitter #(.WAIT_CYCLES(W), .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
        .clk(clk), .btn(btn), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .uart_tx(uart_tx), .tx_busy(tx_busy)
    );

    uart_transmitter #(.WAIT_CYCLES(W), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
        .clk(clk), .btn(btn), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .uart_tx(uart_tx2), .tx_busy(tx_busy2)
    );

    function automatic logic line(input int sel);
        return (sel != 0) ? uart_tx2 : uart_tx;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge, acc = that edge number.
    task automatic push(input int sel, input logic [7:0] b, output int acc);
        int  guard;
        bit  rdy;
        guard = 0;
        if (sel != 0) begin tx_valid2 = 1'b1; tx_data2 = b; end
        else          begin tx_valid  = 1'b1; tx_data  = b; end
        forever begin
            rdy = (sel != 0) ? tx_ready2 : tx_ready;
            @(posedge clk);
            @(negedge clk);
            if (rdy) break;
            guard++;
            if (guard > 300) begin
                n_checks++; n_fail++;
                $display("FAIL push_timeout dut%0d: byte %02h never accepted", sel, b);
                break;
            end
        end
        acc = cyc;
    endtask

    // Receiver model: waits for a start bit, samples mid-bit, checks start and stop levels.
    task automatic rx_frame(input int sel, input int nstop, output logic [7:0] b, output int st);
        int g;
        g  = 0;
        b  = 8'h00;
        st = -1;
        while (line(sel) !== 1'b0) begin
            @(negedge clk);
            g++;
            if (g > 400) begin
                n_checks++; n_fail++;
                $display("FAIL rx_start_timeout dut%0d: line stayed %b, required a start bit", sel, line(sel));
                return;
            end
        end
        st = cyc;
        repeat (W / 2) @(negedge clk);
        n_checks++;
        if (line(sel) !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_start_bit dut%0d: got %b required 0", sel, line(sel));
        end
        for (int i = 0; i < 8; i++) begin
            repeat (W) @(negedge clk);
            b[i] = line(sel);
        end
        for (int s = 0; s < nstop; s++) begin
            repeat (W) @(negedge clk);
            n_checks++;
            if (line(sel) !== 1'b1) begin
                n_fail++;
                $display("FAIL rx_stop_bit%0d dut%0d: got %b required 1", s, sel, line(sel));
            end
        end
    endtask

    task automatic test_reset;
        btn = 1'b0; tx_valid = 1'b0; tx_valid2 = 1'b0; tx_data = 8'h00; tx_data2 = 8'h00;
        repeat (3) @(negedge clk);
        btn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_checks++;
            if ({uart_tx, tx_ready, tx_busy} !== 3'b110) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: {tx,rdy,busy}=%b required 110", k, {uart_tx, tx_ready, tx_busy});
            end
        end
    endtask

    task automatic test_single_frame;
        int         acc;
        logic [7:0] v;
        logic       exp_tx;
        logic       exp_busy;
        v = 8'h4D;
        push(0, v, acc);
        tx_valid = 1'b0;
        for (int k = 1; k <= 82; k++) begin
            @(negedge clk);
            if (k < 2)       exp_tx = 1'b1;
            else if (k < 10) exp_tx = 1'b0;
            else if (k < 74) exp_tx = v[(k - 10) / 8];
            else             exp_tx = 1'b1;
            exp_busy = (k <= 81);
            n_checks++;
            if (uart_tx !== exp_tx || tx_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL single_frame k=%0d: tx=%b busy=%b required tx=%b busy=%b", k, uart_tx, tx_busy, exp_tx, exp_busy);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] pat [5];
        pat = '{8'h4D, 8'h5A, 8'hFF, 8'h00, 8'h81};
        fork
            begin
                int acc [5];
                for (int i = 0; i < 5; i++) push(0, pat[i], acc[i]);
                tx_valid = 1'b0;
                n_checks++;
                if (acc[4] - acc[0] !== 4) begin
                    n_fail++;
                    $display("FAIL b2b_accept: 5th byte accepted %0d clocks after first, required 4", acc[4] - acc[0]);
                end
                n_checks++;
                if (tx_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_full: tx_ready=%b required 0", tx_ready);
                end
                while (cyc < acc[0] + 80) @(negedge clk);
                n_checks++;
                if (tx_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_still_full: tx_ready=%b required 0", tx_ready);
                end
                @(negedge clk);
                n_checks++;
                if (tx_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_slot_freed: tx_ready=%b required 1", tx_ready);
                end
            end
            begin
                logic [7:0] b;
                int         st, prev;
                prev = -1;
                for (int i = 0; i < 5; i++) begin
                    rx_frame(0, 1, b, st);
                    n_checks++;
                    if (b !== pat[i]) begin
                        n_fail++;
                        $display("FAIL b2b_byte%0d: got %02h required %02h", i, b, pat[i]);
                    end
                    if (i > 0) begin
                        n_checks++;
                        if (st - prev !== 80) begin
                            n_fail++;
                            $display("FAIL b2b_gap%0d: frame spacing %0d required 80", i, st - prev);
                        end
                    end
                    prev = st;
                end
            end
        join
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        int         acc, a1, a2, st;
        logic [7:0] b;
        push(0, 8'hA5, acc);
        push(0, 8'h11, a1);
        push(0, 8'h22, a2);
        tx_valid = 1'b0;
        while (cyc < acc + 20) @(negedge clk);
        n_checks++;
        if (uart_tx !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_frame_bit1: tx=%b required 0", uart_tx);
        end
        @(posedge clk);
        btn = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({uart_tx, tx_busy, tx_ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL reset_mid_frame: {tx,busy,rdy}=%b required 101", {uart_tx, tx_busy, tx_ready});
        end
        repeat (2) @(negedge clk);
        btn = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            n_checks++;
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_quiet k=%0d: tx=%b busy=%b required 1 0", k, uart_tx, tx_busy);
            end
        end
        push(0, 8'h3C, acc);
        tx_valid = 1'b0;
        rx_frame(0, 1, b, st);
        n_checks++;
        if (b !== 8'h3C || st - acc !== 2) begin
            n_fail++;
            $display("FAIL post_reset_frame: byte %02h start+%0d required 3c start+2", b, st - acc);
        end
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            n_checks++;
            if (uart_tx !== 1'b1) begin
                n_fail++;
                $display("FAIL post_reset_extra k=%0d: tx=%b required 1", k, uart_tx);
                break;
            end
        end
        n_checks++;
        if (tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_busy: busy=%b required 0", tx_busy);
        end
    endtask

    task automatic test_push_pop_same_clock;
        logic [7:0] pat [6];
        pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        fork
            begin
                int acc [6];
                for (int i = 0; i < 4; i++) push(0, pat[i], acc[i]);
                tx_valid = 1'b0;
                n_checks++;
                if (tx_ready !== 1'b1 || acc[3] - acc[0] !== 3) begin
                    n_fail++;
                    $display("FAIL pp_three: rdy=%b span=%0d required 1 3", tx_ready, acc[3] - acc[0]);
                end
                while (cyc < acc[0] + 80) @(negedge clk);
                push(0, pat[4], acc[4]);
                n_checks++;
                if (acc[4] - acc[0] !== 81 || tx_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL pp_same_clock: accept at +%0d rdy=%b required +81 1", acc[4] - acc[0], tx_ready);
                end
                push(0, pat[5], acc[5]);
                tx_valid = 1'b0;
                n_checks++;
                if (tx_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL pp_occupancy: rdy=%b after one more push, required 0", tx_ready);
                end
            end
            begin
                logic [7:0] b;
                int         st;
                for (int i = 0; i < 6; i++) begin
                    rx_frame(0, 1, b, st);
                    n_checks++;
                    if (b !== pat[i]) begin
                        n_fail++;
                        $display("FAIL pp_order%0d: got %02h required %02h", i, b, pat[i]);
                    end
                end
            end
        join
        repeat (10) @(negedge clk);
    endtask

    task automatic test_loopback;
        logic [7:0] pat [2];
        logic [7:0] b;
        int         a0, a1, st, prev;
        pat = '{8'h4D, 8'hA6};
        for (int sel = 0; sel < 2; sel++) begin
            push(sel, pat[0], a0);
            push(sel, pat[1], a1);
            if (sel != 0) tx_valid2 = 1'b0;
            else          tx_valid  = 1'b0;
            prev = -1;
            for (int i = 0; i < 2; i++) begin
                rx_frame(sel, sel + 1, b, st);
                n_checks++;
                if (b !== pat[i]) begin
                    n_fail++;
                    $display("FAIL loopback dut%0d byte%0d: got %02h required %02h", sel, i, b, pat[i]);
                end
                if (i > 0) begin
                    n_checks++;
                    if (st - prev !== (sel != 0 ? 88 : 80)) begin
                        n_fail++;
                        $display("FAIL loopback_len dut%0d: spacing %0d required %0d", sel, st - prev, (sel != 0 ? 88 : 80));
                    end
                end
                prev = st;
            end
            repeat (20) @(negedge clk);
        end
        n_checks++;
        if (tx_busy !== 1'b0 || tx_busy2 !== 1'b0 || uart_tx2 !== 1'b1) begin
            n_fail++;
            $display("FAIL final_idle: busy=%b busy2=%b tx2=%b required 0 0 1", tx_busy, tx_busy2, uart_tx2);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        repeat (5) @(negedge clk);
        test_back_to_back();
        test_reset_mid_frame();
        test_push_pop_same_clock();
        test_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
